ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; opposite direction of the existing PS2 receiver on PS2_clk/PS2_data.

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Optional build macro PS2_TX_RETRY_EN re-sends the same byte up to MAX_RETRY times before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev, sync_clk, sync_data, fall;
    logic [9:0]       frame, frame_nx;      // {stop, parity, data[7:0]}
    logic [3:0]       bit_idx, bit_idx_nx;
    logic             cur_bit, cur_bit_nx;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nx;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic             failure;
`ifdef PS2_TX_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] retry_cnt, retry_cnt_nx;
`endif

    // Synchronisers idle high so a released bus never looks like a falling edge out of reset.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign fall      = clk_prev & ~sync_clk;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            frame     <= '0;
            bit_idx   <= '0;
            cur_bit   <= 1'b0;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state     <= state_nx;
            frame     <= frame_nx;
            bit_idx   <= bit_idx_nx;
            cur_bit   <= cur_bit_nx;
            inh_cnt   <= inh_cnt_nx;
            tmo_cnt   <= tmo_cnt_nx;
`ifdef PS2_TX_RETRY_EN
            retry_cnt <= retry_cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        frame_nx     = frame;
        bit_idx_nx   = bit_idx;
        cur_bit_nx   = cur_bit;
        inh_cnt_nx   = inh_cnt;
        tmo_cnt_nx   = tmo_cnt;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_nx = retry_cnt;
`endif
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        tx_done      = 1'b0;
        tx_err       = 1'b0;
        failure      = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    frame_nx     = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_nx   = '0;
                    state_nx     = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_cnt_nx = '0;
`endif
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (inh_cnt == INH_LAST);
                if (inh_cnt == INH_LAST) begin
                    inh_cnt_nx = '0;
                    tmo_cnt_nx = '0;
                    state_nx   = S_RTS;
                end else begin
                    inh_cnt_nx = inh_cnt + 1'b1;
                end
            end
            S_RTS: begin
                ps2_data_oe = 1'b1;
                tmo_cnt_nx  = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LIMIT) begin
                    failure = 1'b1;
                end else if (fall) begin
                    cur_bit_nx = frame[0];
                    bit_idx_nx = 4'd1;
                    state_nx   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ps2_data_oe = ~cur_bit;
                tmo_cnt_nx  = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LIMIT) begin
                    failure = 1'b1;
                end else if (fall) begin
                    cur_bit_nx = frame[bit_idx];
                    bit_idx_nx = bit_idx + 4'd1;
                    if (bit_idx == 4'd9) state_nx = S_ACK;
                end
            end
            S_ACK: begin
                tmo_cnt_nx = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LIMIT) begin
                    failure = 1'b1;
                end else if (fall) begin
                    if (!sync_data) state_nx = S_WAIT_IDLE;
                    else            failure  = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                tmo_cnt_nx = tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LIMIT) begin
                    failure = 1'b1;
                end else if (sync_clk && sync_data) begin
                    tx_done  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // A failure releases both lines in the same cycle it is detected.
        if (failure) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt < RTY_MAX) begin
                retry_cnt_nx = retry_cnt + 1'b1;
                inh_cnt_nx   = '0;
                state_nx     = S_INHIBIT;
            end else begin
                tx_err   = 1'b1;
                state_nx = S_IDLE;
            end
`else
            tx_err   = 1'b1;
            state_nx = S_IDLE;
`endif
        end
    end

    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model plus a transaction-level reference checked every cycle.
module tb_ps2_host_tx;
    localparam int N  = 100;
    localparam int T  = 5000;
    localparam int MR = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int ERR_PHASES = MR + 1;
`else
    localparam int ERR_PHASES = 1;
`endif
    localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

    logic clk = 1'b0, RSTN = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic ps2_clk_w, ps2_data_w;

    assign ps2_clk_w  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_w = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .RSTN(RSTN), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
        .ps2_clk_in(ps2_clk_w), .ps2_data_in(ps2_data_w),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    int dev_mode = M_ACK;
    bit dev_active = 1'b0;
    int dev_bits = 0;
    logic [9:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] last_frame = '0;
    bit m_busy = 1'b0;
    int m_inh_left = 0, m_rts = 0, m_phases = 0, m_clkoe_cnt = 0;
    int cyc = 0, n_done = 0, n_errp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wire image of a byte as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device: clocks 10 bits in (sampled on rising edges), then an ACK pulse.
    task automatic do_frame();
        logic [9:0] cap;
        int h;
        cap = '0;
        dev_active = 1'b1;
        dev_bits = 0;
        h = $urandom_range(30, 60);
        tick($urandom_range(20, 80));
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1; tick(h);
            dev_clk_low = 1'b0; cap[i] = ps2_data_w; dev_bits++; tick(h);
        end
        cap_q.push_back(cap);
        if (dev_mode == M_ACK) dev_data_low = 1'b1;
        tick(2);
        dev_clk_low = 1'b1; tick(h);
        dev_clk_low = 1'b0; tick(h);
        dev_data_low = 1'b0;
        dev_active = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (RSTN && ps2_clk_w && !ps2_data_w && dev_mode != M_SILENT) do_frame();
        end
    end

    // Reference: idle/busy phases, inhibit window of N cycles, timeout distance, frame contents.
    always @(negedge clk) begin
        bit ending;
        logic [7:0] b;
        ending = 1'b0;
        cyc++;
        if (!RSTN) begin
            m_busy = 1'b0;
            m_inh_left = 0;
            exp_q.delete();
        end else begin
            check("ready", tx_ready, !m_busy);
            check("busy", busy, m_busy);
            check("done_err_excl", tx_done & tx_err, 1'b0);
            if (!m_busy) begin
                check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check("idle_pulse", {tx_done, tx_err}, 2'b00);
            end else if (m_inh_left > 0) begin
                check("inh_clk_oe", ps2_clk_oe, 1'b1);
                check("inh_data_oe", ps2_data_oe, m_inh_left == 1);
                check("inh_pulse", {tx_done, tx_err}, 2'b00);
                m_clkoe_cnt++;
                m_inh_left--;
                if (m_inh_left == 0) m_rts = cyc + 1;
            end else if (ps2_clk_oe) begin
`ifdef PS2_TX_RETRY_EN
                m_phases++;
                m_clkoe_cnt++;
                if (dev_mode == M_SILENT) check("retry_time", cyc - m_rts, T + 1);
                check("retry_data_oe", ps2_data_oe, N == 1);
                m_inh_left = N - 1;
                if (m_inh_left == 0) m_rts = cyc + 1;
`else
                check("clk_oe_after_inhibit", ps2_clk_oe, 1'b0);
`endif
            end else if (tx_done || tx_err) begin
                check("end_data_oe", ps2_data_oe, 1'b0);
                if (tx_err && dev_mode == M_SILENT) check("timeout_time", cyc - m_rts, T);
                b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                if (tx_done) check("done_frames", cap_q.size(), 1);
                foreach (cap_q[i]) begin
                    check("frame_bits", cap_q[i], frame_of(b));
                    last_frame = cap_q[i];
                end
                cap_q.delete();
                if (tx_done) n_done++; else n_errp++;
                ending = 1'b1;
            end
            if (ending) begin
                m_busy = 1'b0;
            end else if (!m_busy && tx_valid) begin
                m_busy = 1'b1;
                m_inh_left = N;
                m_phases = 1;
                m_clkoe_cnt = 0;
                exp_q.push_back(tx_data);
            end
        end
    end

    task automatic wait_quiet(input string name);
        int k = 0;
        while ((dev_active || busy) && k < 20000) begin @(posedge clk); #1; k++; end
        check({name, "_quiet_bound"}, k < 20000, 1'b1);
    endtask

    task automatic wait_end(input string name, input int d0, input int e0);
        int k = 0;
        while (n_done == d0 && n_errp == e0 && k < 60000) begin @(posedge clk); #1; k++; end
        check({name, "_end_bound"}, k < 60000, 1'b1);
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!busy && k < 100) begin @(posedge clk); #1; k++; end
        check({name, "_accept_bound"}, k < 100, 1'b1);
    endtask

    task automatic run_txn(input logic [7:0] b, input int mode, input string name, input int exp_done);
        int d0, e0;
        wait_quiet({name, "_pre"});
        dev_mode = mode;
        d0 = n_done;
        e0 = n_errp;
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data = $urandom;
        wait_end(name, d0, e0);
        check({name, "_done"}, n_done - d0, exp_done);
        check({name, "_err"}, n_errp - e0, 1 - exp_done);
        wait_quiet(name);
    endtask

    initial begin
        int d0, e0, k;
        logic [7:0] rb;
        // reset state
        tick(3);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_pulse", {tx_done, tx_err}, 2'b00);
        RSTN = 1'b1;
        tick(5);

        // 1: 0xED, device ACKs
        run_txn(8'hED, M_ACK, "t1_ed", 1);
        check("t1_wire_bits", last_frame, 10'h3ED);

        // 2: 0xF4, parity 0, inhibit length
        run_txn(8'hF4, M_ACK, "t2_f4", 1);
        check("t2_wire_bits", last_frame, 10'h2F4);
        check("t2_inhibit_cycles", m_clkoe_cnt, 100);

        // 3: device NACKs
        run_txn(8'h55, M_NACK, "t3_nack", 0);
        check("t3_phases", m_phases, ERR_PHASES);

        // 4: device never clocks
        run_txn(8'hF4, M_SILENT, "t4_silent", 0);
        check("t4_phases", m_phases, ERR_PHASES);
        dev_mode = M_ACK;

        // 5: reset after the 4th data bit
        d0 = n_done;
        e0 = n_errp;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        k = 0;
        while (dev_bits < 4 && k < 20000) begin @(posedge clk); #1; k++; end
        check("t5_bits_bound", k < 20000, 1'b1);
        #2;
        RSTN = 1'b0;
        #1;
        check("t5_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("t5_rst_ready", tx_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_rst_pulse", {tx_done, tx_err}, 2'b00);
        end
        @(posedge clk); #2;
        RSTN = 1'b1;
        wait_quiet("t5_abort");
        check("t5_no_done", n_done, d0);
        check("t5_no_err", n_errp, e0);
        cap_q.delete();
        run_txn(8'hF4, M_ACK, "t5_f4", 1);
        check("t5_wire_bits", last_frame, 10'h2F4);

        // 6: tx_valid held with 0xAA during the 0xED frame
        wait_quiet("t6_pre");
        d0 = n_done;
        tx_data = 8'hED;
        tx_valid = 1'b1;
        wait_busy("t6_ed");
        tx_data = 8'hAA;
        wait_end("t6_ed", d0, n_errp);
        check("t6_ed_bits", last_frame, 10'h3ED);
        wait_busy("t6_aa");
        tx_valid = 1'b0;
        d0 = n_done;
        wait_end("t6_aa", d0, n_errp);
        check("t6_aa_bits", last_frame, 10'h3AA);
        check("t6_total_done", n_done, d0 + 1);
        wait_quiet("t6_post");

        // random bytes with random idle gaps and device timing
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
            rb = $urandom;
            run_txn(rb, M_ACK, "rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
